wash_cycle_ctrl: RTL
====================

# wash_cycle_ctrl

Washing-machine cycle sequencer that drives the shared 10-bit tick timer and consumes its duration strobes. It drives the timer's restart (`timer_rst_n`) and freeze (`timer_stop`) inputs and advances on `done1u`/`done2u`/`done5u`. It sits between the user-input logic (start, pause, cancel, door sensor) and the actuator drivers (valve, motor, door lock).

## Interface
- `STATE_W`, default 3, width of the `state` status output.
- `clk` input 1: clock.
- `reset_n` input 1: reset, synchronous, active-low.
- `start` input 1: level; requests a cycle from IDLE.
- `pause` input 1: level; freezes the cycle while high.
- `cancel` input 1: level; aborts to SPIN (drain).
- `door_closed` input 1: door sensor; low acts as pause while running.
- `double_wash` input 1: selects a second WASH+RINSE pass; sampled at start.
- `done1u`, `done2u`, `done5u` input 1 each: timer strobes, high while timer count equals 99, 199 or 499 respectively.
- `timer_rst_n` output 1: registered; drives the timer's synchronous active-low reset.
- `timer_stop` output 1: registered; freezes the timer count.
- `water_valve`, `motor_on`, `motor_spin`, `door_lock` output 1 each: actuator enables.
- `wash_done` output 1: registered one-cycle pulse at cycle completion.
- `state` output STATE_W: current state encoding.

## Operation
- State encoding: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4.
- Transitions:
  - IDLE→FILL when `start & door_closed`.
  - FILL→WASH on `done1u`.
  - WASH→RINSE on `done5u`.
  - RINSE→WASH on `done2u` if `second_pass` is pending; otherwise RINSE→SPIN on `done2u`.
  - SPIN→IDLE on `done1u`, which also pulses `wash_done`.
- `second_pass` flag:
  - Loaded from `double_wash` on IDLE→FILL.
  - Cleared on the RINSE→WASH transition.
  - Cleared in IDLE.
- Timer restart: every state change, including entry to IDLE, registers `timer_rst_n=0` for exactly one cycle. In IDLE, `timer_rst_n` is held 0 and `timer_stop`=1, so the timer stays parked at 0.
- Strobe masking: `done*` inputs are ignored in any cycle where registered `timer_rst_n=0` or `paused_q=1`.
- Pause: `paused_q` registers `(pause | ~door_closed)` in FILL, WASH, RINSE and SPIN. It is 0 in IDLE.
- `timer_stop` registers `(IDLE) | paused_next`.
- While `paused_q=1`, `water_valve`, `motor_on` and `motor_spin` are 0, and the state holds.
- Cancel:
  - In FILL, WASH or RINSE with `paused_q=0`, the next state is SPIN.
  - Cancel takes priority over a same-cycle done strobe.
  - Cancel is ignored in IDLE and SPIN.
- Actuator decode (Moore, from `state` and `paused_q`):
  - `water_valve` = (FILL | RINSE) & ~paused_q.
  - `motor_on` = (WASH | RINSE | SPIN) & ~paused_q.
  - `motor_spin` = SPIN & ~paused_q.
  - `door_lock` = state≠IDLE.
- Reset mid-operation forces IDLE and clears `second_pass` and `paused_q`. All outputs take their reset values.

## Timing
- Reset values:
  - `state`=IDLE, `timer_rst_n`=0, `timer_stop`=1, `wash_done`=0.
  - `water_valve`=0, `motor_on`=0, `motor_spin`=0, `door_lock`=0.
- Dwell, unpaused, measured in clk edges from entry edge to exit edge:
  - FILL and SPIN: 101.
  - RINSE: 201.
  - WASH: 501.
  - Each dwell is 1 restart cycle plus (strobe count + 1).
- Full single cycle from the `start`-sampling edge to the `wash_done` edge is 101+501+201+101 = 904 edges. With double wash it is 1606.
- Pause latency:
  - The timer freezes one edge after `pause` is sampled, so the count advances at most once after pause.
  - A strobe asserted at freeze stays high through the pause and is honored on the second edge after release. Strobes are never lost.
- `wash_done` is high for exactly the one cycle following the SPIN→IDLE edge.
- `start` held high after completion re-triggers FILL on the edge after IDLE entry, provided the door is closed.

## Configuration
- `WASH_DOUBLE_PASS_EN` defined: `double_wash` is honored as described above.
- `WASH_DOUBLE_PASS_EN` undefined: `second_pass` is tied to 0 and the `double_wash` port remains but is ignored. Always a single pass, 904 edges.

## Test plan
- Nominal: reset, `start=1` with door closed, bench timer instantiated → states 1,2,3,4,0 at edges +1, +102, +603, +804, +905; `wash_done` 1-cycle pulse; `door_lock` 1 throughout.
- Double wash (macro defined): `double_wash=1` at start → WASH entered twice; `wash_done` at edge +1607. With macro undefined → +905.
- Pause in WASH: `pause=1` for 50 cycles at WASH+200 → timer frozen, `motor_on`=0, WASH exit delayed by exactly 50 edges.
- Pause landing on a strobe: pause asserted the cycle `done5u` rises → state holds; `done5u` stays 1; transition to RINSE on the second edge after release.
- Cancel during FILL at +40 with a simultaneous-strobe variant → next state SPIN, timer restarted, IDLE reached 101 edges later; cancel in SPIN has no effect.
- Mid-cycle `reset_n=0` in RINSE → next edge: `state`=0, `timer_rst_n`=0, `timer_stop`=1, all actuators 0; door open plus `start` in IDLE → stays IDLE.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer: IDLE -> FILL -> WASH -> RINSE [-> WASH -> RINSE] -> SPIN.
// Optional second wash pass is compiled in with `define WASH_DOUBLE_PASS_EN.
module wash_cycle_ctrl #(
   parameter int STATE_W = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               pause,
   input  logic               cancel,
   input  logic               door_closed,
   input  logic               double_wash,
   input  logic               done1u,
   input  logic               done2u,
   input  logic               done5u,
   output logic               timer_rst_n,
   output logic               timer_stop,
   output logic               water_valve,
   output logic               motor_on,
   output logic               motor_spin,
   output logic               door_lock,
   output logic               wash_done,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_WASH  = 3'd2,
      S_RINSE = 3'd3,
      S_SPIN  = 3'd4
   } state_t;

   state_t state_q, state_d;
   logic   second_pass_q;
   logic   paused_q, paused_d;
   logic   timer_rst_n_q, timer_rst_n_d;
   logic   timer_stop_q, timer_stop_d;
   logic   wash_done_q, wash_done_d;
   logic   strobe_ok;

   always_comb begin
      state_d   = state_q;
      // Strobes are stale during the restart cycle and frozen-valid while paused.
      strobe_ok = timer_rst_n_q & ~paused_q;
      case (state_q)
         S_IDLE: begin
            if (start && door_closed) state_d = S_FILL;
         end
         S_FILL: begin
            if (cancel && !paused_q)        state_d = S_SPIN;
            else if (strobe_ok && done1u)   state_d = S_WASH;
         end
         S_WASH: begin
            if (cancel && !paused_q)        state_d = S_SPIN;
            else if (strobe_ok && done5u)   state_d = S_RINSE;
         end
         S_RINSE: begin
            if (cancel && !paused_q)        state_d = S_SPIN;
            else if (strobe_ok && done2u)   state_d = second_pass_q ? S_WASH : S_SPIN;
         end
         S_SPIN: begin
            if (strobe_ok && done1u)        state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      paused_d      = (state_d != S_IDLE) & (pause | ~door_closed);
      timer_stop_d  = (state_d == S_IDLE) | paused_d;
      timer_rst_n_d = (state_d == state_q) & (state_d != S_IDLE);
      wash_done_d   = (state_q == S_SPIN) & (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         paused_q      <= 1'b0;
         timer_rst_n_q <= 1'b0;
         timer_stop_q  <= 1'b1;
         wash_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         paused_q      <= paused_d;
         timer_rst_n_q <= timer_rst_n_d;
         timer_stop_q  <= timer_stop_d;
         wash_done_q   <= wash_done_d;
      end
   end

`ifdef WASH_DOUBLE_PASS_EN
   logic second_pass_d;

   always_comb begin
      second_pass_d = second_pass_q;
      if (state_q == S_IDLE)
         second_pass_d = start & door_closed & double_wash;
      else if ((state_q == S_RINSE) && (state_d == S_WASH))
         second_pass_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) second_pass_q <= 1'b0;
      else          second_pass_q <= second_pass_d;
   end
`else
   assign second_pass_q = 1'b0 & double_wash;
`endif

   assign timer_rst_n = timer_rst_n_q;
   assign timer_stop  = timer_stop_q;
   assign wash_done   = wash_done_q;
   assign water_valve = ((state_q == S_FILL) | (state_q == S_RINSE)) & ~paused_q;
   assign motor_on    = ((state_q == S_WASH) | (state_q == S_RINSE) | (state_q == S_SPIN)) & ~paused_q;
   assign motor_spin  = (state_q == S_SPIN) & ~paused_q;
   assign door_lock   = (state_q != S_IDLE);
   assign state       = STATE_W'(state_q);

endmodule
